// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg
//   Shared definitions for the CPU pipeline elastic registers:
//   - skid register state encoding
//   - default data and stall-counter widths
package cpu_pipe_pkg;

  localparam int W_DATA  = 32;
  localparam int W_STALL = 16;

  // 2'b11 is never entered; if it ever appears, the next edge recovers to ST_EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter. It advances on the falling edge, like the
//   datapath registers it sits beside.
// Ports:
//   clk    in   clock (state updates on negedge)
//   reset  in   synchronous active-high clear
//   inc    in   add one this cycle unless already at all-ones
//   q      out  current count
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] q
);

  logic [CW-1:0] q_q;
  logic [CW-1:0] q_d;

  always_comb begin
    q_d = q_q;
    // Stop at all-ones rather than wrapping back to zero.
    if (inc && (q_q != {CW{1'b1}})) begin
      q_d = q_q + CW'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_skid_register.sv
// pipe_skid_register
//   Two-entry elastic pipeline register with valid/ready on both sides.
//   It sustains one word per cycle with one cycle of latency. It also
//   counts, with saturation, the cycles in which the consumer stalls a
//   valid word.
// Ports:
//   clk           in   clock (state updates on negedge)
//   reset         in   synchronous active-high reset
//   flush         in   synchronous flush; drops all held words
//   in_valid      in   producer word available
//   in_ready      out  block can accept a word this cycle
//   in_data       in   producer word
//   out_valid     out  out_data is valid
//   out_ready     in   consumer takes out_data this cycle
//   out_data      out  oldest held word
//   stall_cycles  out  saturating count of out_valid & ~out_ready cycles
module pipe_skid_register
  import cpu_pipe_pkg::*;
#(
  parameter int W  = W_DATA,
  parameter int CW = W_STALL
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] stall_cycles
);

  skid_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire;
  logic         out_fire;

  // in_ready depends only on registered state (and reset). This keeps any
  // combinational path from out_ready back to the producer out of the design.
  assign in_ready  = ~reset & (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any handshake that fires in the flush cycle is discarded along with the held words.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire && !in_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire && out_fire) begin
            main_d = in_data;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the consumer side can move.
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // flush does not gate the increment; only reset clears the count.
  sat_counter #(.CW(CW)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .q     (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_skid_register.sv
module tb_pipe_skid_register;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] stall_cycles;

  // Second instance with a narrow counter for the saturation check.
  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_data;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_data;
  logic [3:0]  s_stall;

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_skid_register #(.W(32), .CW(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .stall_cycles (stall_cycles)
  );

  pipe_skid_register #(.W(32), .CW(4)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .flush        (s_flush),
    .in_valid     (s_in_valid),
    .in_ready     (s_in_ready),
    .in_data      (s_in_data),
    .out_valid    (s_out_valid),
    .out_ready    (s_out_ready),
    .out_data     (s_out_data),
    .stall_cycles (s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs, let the falling edge consume them, and return just after.
  task automatic step(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    reset = 1'b0;
  endtask

  // Reference model, sampled on the rising edge (mid-cycle, inputs stable).
  logic [31:0] sb[$];
  logic [15:0] exp_stall = '0;
  bit          live      = 1'b0;
  bit          m_zero    = 1'b1;
  bit          m_valid, m_ready, m_in_f, m_out_f;

  initial begin
    forever begin
      @(posedge clk);
      m_valid = (sb.size() != 0);
      m_ready = !reset && (sb.size() < 2);
      if (reset) check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
      if (live) begin
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (!reset) check_eq("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
        check_eq("stall", {16'b0, stall_cycles}, {16'b0, exp_stall});
        if (m_valid) begin
          check_eq("out_data", out_data, sb[0]);
        end else if (m_zero) begin
          check_eq("out_data_zero", out_data, 32'd0);
        end
      end
      if (reset) begin
        sb.delete();
        exp_stall = '0;
        live      = 1'b1;
        m_zero    = 1'b1;
      end else begin
        if (m_valid && !out_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        if (flush) begin
          sb.delete();
          m_zero = 1'b1;
        end else begin
          m_in_f  = in_valid && m_ready;
          m_out_f = m_valid && out_ready;
          if (m_out_f) begin
            $display("[TB] t=%0t out 0x%0h", $time, out_data);
            void'(sb.pop_front());
          end
          if (m_in_f) begin
            $display("[TB] t=%0t in  0x%0h", $time, in_data);
            sb.push_back(in_data);
            m_zero = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b1;
    in_data     = 32'hDEAD;
    out_ready   = 1'b0;
    s_flush     = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = 32'h0;
    s_out_ready = 1'b0;

    // 1. Reset with a word offered: ignored, outputs clean.
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    check_eq("t1_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("t1_out_data", out_data, 32'd0);
    check_eq("t1_stall", {16'b0, stall_cycles}, 32'd0);
    check_eq("t1_in_ready_rst", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("t1_in_ready_after", {31'b0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // 2. Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, i, 1'b1, 1'b0);
      check_eq("t2_in_ready", {31'b0, in_ready}, 32'd1);
      check_eq("t2_latency", out_data, i);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("t2_stall", {16'b0, stall_cycles}, 32'd0);

    // 3. Back-pressure fills the skid slot.
    do_reset();
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    check_eq("t3_full_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("t3_head", out_data, 32'hA);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    check_eq("t3_stall", {16'b0, stall_cycles}, 32'd2);
    check_eq("t3_head_held", out_data, 32'hA);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("t3_second", out_data, 32'hB);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("t3_drained", {31'b0, out_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // 4. Accept and deliver in the same cycle while holding one word.
    do_reset();
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b1, 1'b0);
    check_eq("t4_out_data", out_data, 32'h6);
    check_eq("t4_in_ready", {31'b0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // 5. Flush from FULL with both sides firing.
    do_reset();
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("t5_stall_pre", {16'b0, stall_cycles}, 32'd3);
    step(1'b1, 32'h33, 1'b1, 1'b1);
    check_eq("t5_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("t5_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("t5_stall", {16'b0, stall_cycles}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check_eq("t5_empty", {31'b0, out_valid}, 32'd0);
    end

    // 6. Saturation of a 4-bit stall counter.
    do_reset();
    s_in_valid = 1'b1;
    s_in_data  = 32'h7;
    @(negedge clk);
    #1;
    s_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      if (k == 5)  check_eq("t6_stall_5", {28'b0, s_stall}, 32'd5);
      if (k == 15) check_eq("t6_stall_15", {28'b0, s_stall}, 32'd15);
    end
    check_eq("t6_stall_hold", {28'b0, s_stall}, 32'd15);
    check_eq("t6_valid", {31'b0, s_out_valid}, 32'd1);
    check_eq("t6_data", s_out_data, 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
